// File: rtl/ps2_command_out.sv
// PS/2 host-to-device command transmitter.
// Request-to-send, device-clocked 11-bit frame, ack check and timeouts.
module ps2_command_out #(
    parameter int CLK_INHIBIT_CYCLES   = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int FRAME_TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam int MAX_AB =
        (CLK_INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
        CLK_INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES =
        (MAX_AB > FRAME_TIMEOUT_CYCLES) ? MAX_AB : FRAME_TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(CLK_INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] FRAME_LAST   = TW'(FRAME_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_DATA,
        S_ACK,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [9:0]    frame;
    logic [3:0]    bit_count;
    logic          tx_bit;
    logic [TW-1:0] timer;
    logic          timing;
    logic          frame_expired;
    logic          unused_posedge;

    assign unused_posedge = ps2_clk_posedge;

    assign timing = (state == S_INHIBIT) || (state == S_START) ||
                    (state == S_DATA) || (state == S_ACK) ||
                    (state == S_RELEASE);

    assign frame_expired = (timer == FRAME_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (send_command) next_state = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (timer == INHIBIT_LAST) next_state = S_START;
            end
            S_START: begin
                if (ps2_clk_negedge) next_state = S_DATA;
                else if (timer == START_LAST) next_state = S_ERROR;
            end
            S_DATA: begin
                if (frame_expired) next_state = S_ERROR;
                else if (ps2_clk_negedge && bit_count == 4'd9)
                    next_state = S_ACK;
            end
            S_ACK: begin
                if (frame_expired) next_state = S_ERROR;
                else if (ps2_clk_negedge)
                    next_state = ps2_data ? S_ERROR : S_RELEASE;
            end
            S_RELEASE: begin
                if (frame_expired) next_state = S_ERROR;
                else if (ps2_clk && ps2_data) next_state = S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (!send_command) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // The frame timer spans DATA, ACK and RELEASE, so only START/DATA entry restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame     <= '0;
            bit_count <= '0;
            tx_bit    <= 1'b1;
            timer     <= '0;
        end else begin
            if (state == S_IDLE ||
                (next_state != state &&
                 (next_state == S_START || next_state == S_DATA))) begin
                timer <= '0;
            end else if (timing) begin
                timer <= timer + 1'b1;
            end
            if (state == S_IDLE && send_command) begin
                frame     <= {1'b1, ~^the_command, the_command};
                bit_count <= '0;
            end
            if (state == S_START && ps2_clk_negedge) begin
                tx_bit    <= frame[0];
                bit_count <= 4'd1;
            end
            if (state == S_DATA && ps2_clk_negedge) begin
                tx_bit    <= frame[bit_count];
                bit_count <= bit_count + 1'b1;
            end
        end
    end

    always_comb begin
        ps2_clk_drive_low             = 1'b0;
        ps2_data_drive_low            = 1'b0;
        busy                          = (state != S_IDLE);
        command_was_sent              = 1'b0;
        error_communication_timed_out = 1'b0;
        unique case (state)
            S_INHIBIT: ps2_clk_drive_low = 1'b1;
            S_START:   ps2_data_drive_low = 1'b1;
            S_DATA:    ps2_data_drive_low = ~tx_bit;
            S_DONE:    command_was_sent = 1'b1;
            S_ERROR:   error_communication_timed_out = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_command_out.sv
// Testbench for ps2_command_out: a behavioural PS/2 device on the
// open-drain lines, with expected frames derived from the command byte.
module tb_ps2_command_out;

    localparam int INH = 10;
    localparam int STO = 200;
    localparam int FTO = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] the_command;
    logic       send_command;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_posedge;
    logic       ps2_clk_negedge;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;

    logic dev_clk;
    logic dev_data_low;
    logic last_sample;
    int   neg_cyc;
    int   req_lat;
    int   req_low;
    logic req_start;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ps2_command_out #(
        .CLK_INHIBIT_CYCLES  (INH),
        .START_TIMEOUT_CYCLES(STO),
        .FRAME_TIMEOUT_CYCLES(FTO)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .ps2_clk                      (ps2_clk),
        .ps2_data                     (ps2_data),
        .ps2_clk_posedge              (ps2_clk_posedge),
        .ps2_clk_negedge              (ps2_clk_negedge),
        .ps2_clk_drive_low            (ps2_clk_drive_low),
        .ps2_data_drive_low           (ps2_data_drive_low),
        .busy                         (busy),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out)
    );

    // Wired-AND open-drain lines with pull-ups.
    assign ps2_clk  = dev_clk & ~ps2_clk_drive_low;
    assign ps2_data = ~dev_data_low & ~ps2_data_drive_low;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [9:0] expected_line(input logic [7:0] cmd);
        logic [9:0] e;
        int ones;
        ones = $countones(cmd);
        e[7:0] = cmd;
        e[8] = (ones % 2 == 0);
        e[9] = 1'b1;
        return e;
    endfunction

    task automatic dev_tick(input int half);
        @(negedge clk);
        dev_clk = 1'b0;
        ps2_clk_negedge = 1'b1;
        neg_cyc = cyc;
        @(negedge clk);
        ps2_clk_negedge = 1'b0;
        repeat (half) @(negedge clk);
        last_sample = ps2_data;
        dev_clk = 1'b1;
        ps2_clk_posedge = 1'b1;
        @(negedge clk);
        ps2_clk_posedge = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic dev_ack(input int half, input logic pull);
        @(negedge clk);
        dev_data_low = pull;
        dev_tick(half);
        dev_data_low = 1'b0;
    endtask

    task automatic request(input logic [7:0] cmd);
        @(negedge clk);
        the_command = cmd;
        send_command = 1'b1;
        req_lat = 0;
        do begin
            @(negedge clk);
            req_lat++;
        end while (!ps2_clk_drive_low && req_lat < 50);
        the_command = ~cmd;
        req_low = 0;
        while (ps2_clk_drive_low && req_low < 100) begin
            req_low++;
            @(negedge clk);
        end
        req_start = ps2_data_drive_low;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        send_command = 1'b0;
        the_command = 8'h00;
        ps2_clk_posedge = 1'b0;
        ps2_clk_negedge = 1'b0;
        dev_clk = 1'b1;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ps2_clk_drive_low !== 1'b0) begin
            errors++;
            $display("FAIL reset_clk_drive: got %b, expected 0", ps2_clk_drive_low);
        end
        checks++;
        if (ps2_data_drive_low !== 1'b0) begin
            errors++;
            $display("FAIL reset_data_drive: got %b, expected 0", ps2_data_drive_low);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        checks++;
        if ({command_was_sent, error_communication_timed_out} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b%b, expected 00",
                     command_was_sent, error_communication_timed_out);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_command(input logic [7:0] cmd);
        int half;
        int n;
        logic [9:0] seen;
        logic [9:0] exp;
        half = int'($urandom_range(2, 6));
        exp = expected_line(cmd);
        seen = '0;
        request(cmd);
        checks++;
        if (req_lat !== 1) begin
            errors++;
            $display("FAIL req_latency_%h: got %0d, expected 1", cmd, req_lat);
        end
        checks++;
        if (req_low !== INH) begin
            errors++;
            $display("FAIL inhibit_len_%h: got %0d, expected %0d", cmd, req_low, INH);
        end
        checks++;
        if (req_start !== 1'b1) begin
            errors++;
            $display("FAIL start_bit_%h: got %b, expected 1", cmd, req_start);
        end
        repeat ($urandom_range(1, 20)) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            dev_tick(half);
            seen[k] = last_sample;
        end
        checks++;
        if (seen !== exp) begin
            errors++;
            $display("FAIL frame_%h: got %b, expected %b", cmd, seen, exp);
        end
        dev_ack(half, 1'b1);
        n = 0;
        while (!command_was_sent && !error_communication_timed_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({command_was_sent, error_communication_timed_out, busy} !== 3'b101) begin
            errors++;
            $display("FAIL done_%h: sent/err/busy got %b%b%b, expected 101", cmd,
                     command_was_sent, error_communication_timed_out, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (command_was_sent !== 1'b1) begin
            errors++;
            $display("FAIL done_hold_%h: got %b, expected 1", cmd, command_was_sent);
        end
        send_command = 1'b0;
        @(negedge clk);
        checks++;
        if ({command_was_sent, busy} !== 2'b00) begin
            errors++;
            $display("FAIL done_clear_%h: sent/busy got %b%b, expected 00", cmd,
                     command_was_sent, busy);
        end
    endtask

    task automatic test_start_timeout;
        int cs;
        request(8'hF4);
        cs = cyc;
        while (!error_communication_timed_out && cyc - cs < 400) @(negedge clk);
        checks++;
        if (error_communication_timed_out !== 1'b1 || cyc - cs !== STO) begin
            errors++;
            $display("FAIL start_timeout: err %b after %0d cycles, expected 1 after %0d",
                     error_communication_timed_out, cyc - cs, STO);
        end
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, command_was_sent} !== 3'b000) begin
            errors++;
            $display("FAIL start_timeout_lines: clk/data/sent got %b%b%b, expected 000",
                     ps2_clk_drive_low, ps2_data_drive_low, command_was_sent);
        end
        send_command = 1'b0;
        @(negedge clk);
        checks++;
        if ({error_communication_timed_out, busy} !== 2'b00) begin
            errors++;
            $display("FAIL start_timeout_clear: err/busy got %b%b, expected 00",
                     error_communication_timed_out, busy);
        end
    endtask

    task automatic test_ack_error;
        int n;
        request(8'h55);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 10; k++) dev_tick(3);
        dev_ack(3, 1'b0);
        n = 0;
        while (!command_was_sent && !error_communication_timed_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({error_communication_timed_out, command_was_sent} !== 2'b10) begin
            errors++;
            $display("FAIL ack_error: err/sent got %b%b, expected 10",
                     error_communication_timed_out, command_was_sent);
        end
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin
            errors++;
            $display("FAIL ack_error_lines: got %b%b, expected 00",
                     ps2_clk_drive_low, ps2_data_drive_low);
        end
        send_command = 1'b0;
        @(negedge clk);
        checks++;
        if ({error_communication_timed_out, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ack_error_clear: err/busy got %b%b, expected 00",
                     error_communication_timed_out, busy);
        end
    endtask

    task automatic test_frame_timeout;
        int c0;
        request(8'hA3);
        repeat (4) @(negedge clk);
        dev_tick(4);
        c0 = neg_cyc;
        for (int k = 1; k < 5; k++) dev_tick(4);
        while (!error_communication_timed_out && cyc - c0 < 3000) @(negedge clk);
        checks++;
        if (error_communication_timed_out !== 1'b1 || cyc - c0 !== FTO + 1) begin
            errors++;
            $display("FAIL frame_timeout: err %b after %0d cycles, expected 1 after %0d",
                     error_communication_timed_out, cyc - c0, FTO + 1);
        end
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, command_was_sent} !== 3'b000) begin
            errors++;
            $display("FAIL frame_timeout_lines: clk/data/sent got %b%b%b, expected 000",
                     ps2_clk_drive_low, ps2_data_drive_low, command_was_sent);
        end
        send_command = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_data;
        request(8'h00);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) dev_tick(3);
        checks++;
        if (ps2_data_drive_low !== 1'b1) begin
            errors++;
            $display("FAIL data_bit2_low: got %b, expected 1", ps2_data_drive_low);
        end
        reset = 1'b1;
        send_command = 1'b0;
        @(negedge clk);
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_in_data: clk/data/busy got %b%b%b, expected 000",
                     ps2_clk_drive_low, ps2_data_drive_low, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        test_command(8'hFF);
    endtask

    initial begin
        test_reset;
        test_command(8'hF4);
        test_command(8'hED);
        test_start_timeout;
        test_ack_error;
        test_frame_timeout;
        test_reset_in_data;
        for (int i = 0; i < 6; i++) test_command(8'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
